// File: rtl/control_pkg.sv
// Shared decode definitions for the RV32I pipeline:
// opcodes, ALUOp classes and the ID/EX control bundle.
package control_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/control_decode.sv
// Pure combinational opcode to control-bundle decoder.
// Unknown or X/Z opcodes fall through to the illegal bubble.
module control_decode
  import control_pkg::*;
(
  input  logic [6:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = CTRL_NOP;
    unique case (1'b1)
      (opcode == OP_LOAD): begin
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      (opcode == OP_STORE): begin
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      (opcode == OP_RTYPE): begin
        ctrl.alu_op    = ALUOP_R;
        ctrl.reg_write = 1'b1;
      end
      (opcode == OP_BRANCH): begin
        ctrl.alu_op = ALUOP_SUB;
        ctrl.branch = 1'b1;
      end
      (opcode == OP_IMM): begin
        ctrl.alu_op    = ALUOP_I;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control.sv
// ID-stage control unit: decoded bundle registered into ID/EX
// with flush > stall > load priority.
module control
  import control_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruc,
  input  logic        stall,
  input  logic        flush,
  output logic [1:0]  ALUOp,
  output logic        ALUSrc,
  output logic        branch,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        illegal
);

  ctrl_t dec;
  ctrl_t ctl_q;
  logic  unused_hi;

  assign unused_hi = ^instruc[31:7];

  control_decode u_dec (
    .opcode (instruc[6:0]),
    .ctrl   (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q <= CTRL_NOP;
    end else if (flush) begin
      ctl_q <= CTRL_NOP;
    end else if (!stall) begin
      ctl_q <= dec;
    end
  end

  assign ALUOp      = ctl_q.alu_op;
  assign ALUSrc     = ctl_q.alu_src;
  assign branch     = ctl_q.branch;
  assign mem_read   = ctl_q.mem_read;
  assign mem_write  = ctl_q.mem_write;
  assign reg_write  = ctl_q.reg_write;
  assign mem_to_reg = ctl_q.mem_to_reg;
  assign illegal    = ctl_q.illegal;

endmodule

// File: tb/tb_control.sv
// Self-checking bench for the ID-stage control unit.
// Output vector order: ALUOp,ALUSrc,branch,mem_read,mem_write,reg_write,mem_to_reg,illegal.
module tb_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruc;
  logic        stall;
  logic        flush;
  logic [1:0]  ALUOp;
  logic        ALUSrc;
  logic        branch;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        mem_to_reg;
  logic        illegal;

  int checks   = 0;
  int failures = 0;

  localparam logic [8:0] E_LW   = 9'b00_1_0_1_0_1_1_0;
  localparam logic [8:0] E_SW   = 9'b00_1_0_0_1_0_0_0;
  localparam logic [8:0] E_R    = 9'b10_0_0_0_0_1_0_0;
  localparam logic [8:0] E_BEQ  = 9'b01_0_1_0_0_0_0_0;
  localparam logic [8:0] E_ADDI = 9'b11_1_0_0_0_1_0_0;
  localparam logic [8:0] E_ILL  = 9'b00_0_0_0_0_0_0_1;
  localparam logic [8:0] E_ZERO = 9'b0;

  always #5 clk = ~clk;

  control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instruc    (instruc),
    .stall      (stall),
    .flush      (flush),
    .ALUOp      (ALUOp),
    .ALUSrc     (ALUSrc),
    .branch     (branch),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .illegal    (illegal)
  );

  wire [8:0] outs = {ALUOp, ALUSrc, branch, mem_read,
                     mem_write, reg_write, mem_to_reg, illegal};

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [8:0]  exp;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [8:0] act,
                     input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference decode built from the instruction semantics.
  function automatic logic [8:0] ref_dec(input logic [6:0] op);
    logic ld, st, r, b, i, legal;
    logic [1:0] aop;
    ld = (op === 7'h03);
    st = (op === 7'h23);
    r  = (op === 7'h33);
    b  = (op === 7'h63);
    i  = (op === 7'h13);
    legal = ld | st | r | b | i;
    aop = r ? 2'd2 : b ? 2'd1 : i ? 2'd3 : 2'd0;
    return {aop, ld | st | i, b, ld, st, ld | r | i, ld, ~legal};
  endfunction

  logic [8:0] mdl;
  logic [6:0] ops [5] = '{7'h03, 7'h23, 7'h33, 7'h63, 7'h13};

  initial begin
    tbl[0] = '{"lw_x",   {24'hxxxxxx, 8'h83}, E_LW};
    tbl[1] = '{"sw_x",   {24'hxxxxxx, 8'ha3}, E_SW};
    tbl[2] = '{"r_x",    {24'hxxxxxx, 8'hb3}, E_R};
    tbl[3] = '{"beq_x",  {24'hxxxxxx, 8'he3}, E_BEQ};
    tbl[4] = '{"addi_x", {24'hxxxxxx, 8'h93}, E_ADDI};
    tbl[5] = '{"ill_7f", 32'h0000007f,        E_ILL};

    rst_n   = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
    instruc = 32'h00000033;
    #2;
    chk("reset_async", outs, E_ZERO);
    step();
    chk("reset_held_edge", outs, E_ZERO);
    rst_n = 1'b1;
    step();
    chk("reset_release_r", outs, E_R);

    foreach (tbl[k]) begin
      instruc = tbl[k].instr;
      step();
      chk(tbl[k].name, outs, tbl[k].exp);
    end

    instruc = 32'h00002003;
    step();
    chk("stall_load_lw", outs, E_LW);
    stall   = 1'b1;
    instruc = 32'h00002023;
    for (int n = 0; n < 3; n++) begin
      step();
      chk($sformatf("stall_hold_%0d", n), outs, E_LW);
    end
    stall = 1'b0;
    step();
    chk("stall_release_sw", outs, E_SW);

    instruc = 32'h00002003;
    stall   = 1'b1;
    flush   = 1'b1;
    step();
    chk("flush_over_stall", outs, E_ZERO);
    stall = 1'b0;
    flush = 1'b0;

    instruc = 32'h00002003;
    step();
    chk("async_pre_lw", outs, E_LW);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_mid_cycle", outs, E_ZERO);
    step();
    chk("async_held", outs, E_ZERO);
    #2;
    rst_n = 1'b1;
    step();
    chk("async_release_lw", outs, E_LW);

    mdl = E_LW;
    for (int n = 0; n < 300; n++) begin
      logic [6:0] op;
      if ($urandom_range(0, 3) == 0) op = 7'($urandom);
      else op = ops[$urandom_range(0, 4)];
      instruc = {25'($urandom), op};
      stall   = ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 7) == 0);
      if (flush) mdl = E_ZERO;
      else if (!stall) mdl = ref_dec(op);
      step();
      chk($sformatf("rand_%0d_op%02h", n, op), outs, mdl);
      chk("inv_rd_wr", {8'b0, mem_read & mem_write}, E_ZERO);
      chk("inv_m2r_rd", {8'b0, mem_to_reg & ~mem_read}, E_ZERO);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
